// File: rtl/div_pkg.sv
// Shared types and constants for the iterative divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Quotient returned for a zero divisor; sliced to the operand width at use.
  localparam logic [63:0] DZ_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One combinational restoring radix-2 division step.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] divisor,
  input  logic             bit_in,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH:0]   sh;
  logic [WIDTH+1:0] diff;

  // A set top remainder bit means the shifted value certainly exceeds the divisor.
  assign sh      = {rem_in[WIDTH-1:0], bit_in};
  assign diff    = {1'b0, sh} - {2'b00, divisor};
  assign q_bit   = rem_in[WIDTH] | ~diff[WIDTH+1];
  assign rem_out = q_bit ? diff[WIDTH:0] : sh;

endmodule

// File: rtl/div_iter_param.sv
// Iterative restoring divider, RADIX_LOG2 quotient bits per cycle, signed/unsigned.
// Optional DIV_EARLY_TERM_EN skips leading zeros of the dividend to shorten CALC.
module div_iter_param
  import div_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int RADIX_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             flush,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int ITERS = WIDTH / RADIX_LOG2;
  localparam int CW    = $clog2(ITERS + 1);

  state_t           state;
  logic [CW-1:0]    cnt, last;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] dvd, dvs;
  logic             sgn, a_msb, b_msb;

  logic [WIDTH-1:0] abs_a, abs_b, pre_dvd;
  logic [CW-1:0]    pre_last;

  assign abs_a = (sign && a[WIDTH-1]) ? -a : a;
  assign abs_b = (sign && b[WIDTH-1]) ? -b : b;

`ifdef DIV_EARLY_TERM_EN
  always_comb begin
    int lz, lz_r, it;
    lz = WIDTH;
    for (int i = 0; i < WIDTH; i++)
      if (abs_a[i]) lz = WIDTH - 1 - i;
    lz_r = (lz / RADIX_LOG2) * RADIX_LOG2;
    it   = (WIDTH - lz + RADIX_LOG2 - 1) / RADIX_LOG2;
    if (it < 1) it = 1;
    pre_dvd  = abs_a << lz_r;
    pre_last = CW'(it);
  end
`else
  assign pre_dvd  = abs_a;
  assign pre_last = CW'(ITERS);
`endif

  // Cascade of restoring steps; step k consumes dividend bit WIDTH-1-k.
  logic [RADIX_LOG2:0][WIDTH:0] rem_c;
  logic [RADIX_LOG2-1:0]        q_c;

  assign rem_c[0] = rem;

  for (genvar k = 0; k < RADIX_LOG2; k++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_c[k]),
      .divisor (dvs),
      .bit_in  (dvd[WIDTH-1-k]),
      .rem_out (rem_c[k+1]),
      .q_bit   (q_c[RADIX_LOG2-1-k])
    );
  end

  logic neg_q, neg_r;
  assign neg_q = sgn & (a_msb ^ b_msb);
  assign neg_r = sgn & a_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      cnt         <= '0;
      last        <= '0;
      rem         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      sgn         <= 1'b0;
      a_msb       <= 1'b0;
      b_msb       <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            sgn   <= sign;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            if (b == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= DZ_QUOT[WIDTH-1:0];
              remainder   <= a;
            end else begin
              state <= CALC;
              cnt   <= '0;
              last  <= pre_last;
              rem   <= '0;
              dvd   <= pre_dvd;
              dvs   <= abs_b;
            end
          end
        end
        CALC: begin
          if (cnt == last) begin
            // Quotient bits have fully replaced the dividend in dvd.
            state       <= DONE;
            done        <= 1'b1;
            div_by_zero <= 1'b0;
            quotient    <= neg_q ? -dvd : dvd;
            remainder   <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
          end else begin
            rem <= rem_c[RADIX_LOG2];
            dvd <= {dvd[WIDTH-1-RADIX_LOG2:0], q_c};
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_param.sv
// Directed bench for div_iter_param: vector table plus flush/reset/ignore-start sequences.
module tb_div_iter_param;

  localparam int W = 32;
  localparam int R = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic         sign = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  div_iter_param #(.WIDTH(W), .RADIX_LOG2(R)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .flush       (flush),
    .sign        (sign),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quotient    (quotient),
    .remainder   (remainder)
  );

  always @(negedge clk) if (done) done_cnt++;

  typedef struct {
    logic         sgn;
    logic [W-1:0] a, b, q, r;
    logic         dz;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Edges from the start edge until done is seen (0 = done right after the start edge).
  function automatic int exp_lat(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb);
    logic [W-1:0] aa;
    int lz, it;
    if (vb == '0) return 0;
    aa = (s && va[W-1]) ? -va : va;
    lz = W;
    for (int i = 0; i < W; i++) if (aa[i]) lz = W - 1 - i;
    it = (W - lz + R - 1) / R;
    if (it < 1) it = 1;
`ifdef DIV_EARLY_TERM_EN
    return it + 1;
`else
    return W / R + 1;
`endif
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin @(negedge clk); n++; end
    if (busy) chk("wait_idle_timeout", {31'd0, busy}, '0);
  endtask

  task automatic run(input logic s, input logic [W-1:0] va, input logic [W-1:0] vb,
                     output logic [W-1:0] q, output logic [W-1:0] r,
                     output logic dz, output int lat);
    int cyc = 0;
    wait_idle();
    sign = s; a = va; b = vb; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (cyc < 100) begin
      @(negedge clk);
      if (done) break;
      @(posedge clk);
      cyc++;
    end
    if (cyc >= 100) chk("done_timeout", 32'd0, 32'd1);
    q = quotient; r = remainder; dz = div_by_zero; lat = cyc;
  endtask

  initial begin
    logic [W-1:0] q, r;
    logic dz;
    int lat, d0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[3]  = '{1'b0, 32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b1};
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[5]  = '{1'b0, 32'd5,          32'd1,          32'd5,          32'd0,          1'b0};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[7]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
    vecs[8]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'h7FFFFFFC,   32'd1,          1'b0};
    vecs[9]  = '{1'b0, 32'd3,          32'd7,          32'd0,          32'd3,          1'b0};
    vecs[10] = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[11] = '{1'b1, 32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1};
    vecs[12] = '{1'b0, 32'hDEADBEEF,   32'h10,         32'h0DEADBEE,   32'hF,          1'b0};
    vecs[13] = '{1'b0, 32'd1000000,    32'd1000,       32'd1000,       32'd0,          1'b0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, '0);
    chk("reset_done", {31'd0, done}, '0);
    chk("reset_dz",   {31'd0, div_by_zero}, '0);
    chk("reset_q",    quotient, '0);
    chk("reset_r",    remainder, '0);

    // Consecutive runs also exercise back-to-back acceptance right after DONE.
    for (int i = 0; i < 14; i++) begin
      run(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, dz, lat);
      chk($sformatf("v%0d_q", i), q, vecs[i].q);
      chk($sformatf("v%0d_r", i), r, vecs[i].r);
      chk($sformatf("v%0d_dz", i), {31'd0, dz}, {31'd0, vecs[i].dz});
      chk($sformatf("v%0d_lat", i), lat, exp_lat(vecs[i].sgn, vecs[i].a, vecs[i].b));
    end

    // Done is a single-cycle pulse and results hold afterwards.
    run(1'b0, 32'd100, 32'd7, q, r, dz, lat);
    @(negedge clk);
    chk("pulse_done_low", {31'd0, done}, '0);
    chk("pulse_busy_low", {31'd0, busy}, '0);
    repeat (5) @(negedge clk);
    chk("hold_q", quotient, 32'd14);
    chk("hold_r", remainder, 32'd2);

    // Flush during CALC cycle 5: back to IDLE, no done, then a fresh divide.
    wait_idle();
    sign = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("flush_busy", {31'd0, busy}, '0);
    repeat (25) @(negedge clk);
    chk("flush_no_done", done_cnt, d0);
    run(1'b0, 32'd9, 32'd3, q, r, dz, lat);
    chk("after_flush_q", q, 32'd3);
    chk("after_flush_r", r, 32'd0);

    // Start held high in CALC with different operands must not re-sample.
    wait_idle();
    sign = 1'b0; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 a = 32'd9; b = 32'd3;
    repeat (5) @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin @(negedge clk); lat++; end
    chk("ignore_start_q", quotient, 32'd14);
    chk("ignore_start_r", remainder, 32'd2);

    // Reset mid-CALC discards the operation.
    wait_idle();
    sign = 1'b0; a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #3 rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, '0);
    chk("rst_mid_q", quotient, '0);
    repeat (25) @(negedge clk);
    chk("rst_mid_no_done", done_cnt, d0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
